event_encoder8x3: RTL and testbench
===================================

// Module: event_encoder8x3
// PURPOSE
//  Queued 8-to-3 priority encoder. It is the return path for 3-to-8 one-hot select decoding.
//  - Up to 8 event lines raise single-cycle request pulses.
//  - Each pulse is latched into a pending set.
//  - Pending events are emitted one at a time as a 3-bit index on a valid/ready output.
//  - Sits between peripheral event sources and a single consumer (status logger or interrupt FSM).
// PARAMETERS
//  RR_MODE   0  0: fixed priority, lowest index wins; 1: round-robin starting after last grant
// PORTS
//  clk       in   1  rising-edge clock
//  rst_n     in   1  synchronous reset, active-low
//  E         in   1  capture enable; 0 = ignore A, pending still drains
//  A         in   8  event request pulses, one bit per source
//  D         out  3  encoded index of presented event
//  valid     out  1  D holds an event
//  ready     in   1  consumer accepts D this cycle when valid=1
//  pending   out  8  latched, not-yet-presented events
//  overflow  out  1  sticky: an event arrived while its pending bit was already set
//  ovf_clr   in   1  clears overflow
// BEHAVIOUR
//  Clocking and reset
//  - Single clock domain. Synchronous active-low reset: rst_n is sampled on the clk edge.
//  - Reset values: D=3'd0, valid=0, pending=8'h00, overflow=0, last-grant pointer=3'd7.
//  - Reset mid-operation discards the presented and all pending events. No output after reset
//    until a new A pulse arrives.
//  Request capture and selection
//  - Captured set: cap = E ? A : 8'h00.
//  - Candidate set: merged = pending | cap. The selector sees this combinationally, so there is
//    no extra latency.
//  - Selection, RR_MODE=0: lowest set bit of merged.
//  - Selection, RR_MODE=1: first set bit searching ptr+1, ptr+2, ... wrapping 7->0; ptr is the
//    last granted index.
//  FSM IDLE (valid=0)
//  - If merged != 0: D <= sel, valid <= 1, pending <= merged & ~onehot(sel), ptr <= sel, go SHOW.
//  - Otherwise: pending <= merged, stay IDLE.
//  FSM SHOW (valid=1)
//  - D is held stable while ready=0.
//  - ready=0: pending <= pending | cap.
//  - ready=1 and merged != 0: back-to-back load of the next sel in the same cycle. The bubble-free
//    rule is one event accepted per cycle.
//  - ready=1 and merged == 0: valid <= 0, go IDLE. D keeps its last value.
//  Latency
//  - A pulse at edge k with FSM IDLE and empty pending gives valid=1 with its D after edge k
//    (1 cycle).
//  Overflow
//  - Condition, per bit i: cap[i]=1 and pending[i]=1 at the edge.
//  - Effect: overflow <= 1 and the event is merged, i.e. lost.
//  - Not an overflow: cap[i] while index i is only being presented on D, with pending[i] clear.
//    That event is queued as a new event.
//  - Not an overflow: cap[i] in the same cycle bit i is selected from merged. Only sel is
//    removed; a second pulse is impossible in one cycle.
//  - ovf_clr=1 clears overflow. If a new overflow occurs in the same cycle, set wins.
//  Invariants
//  - valid never deasserts without ready=1.
//  - D changes only on load.
//  - pending never holds the index currently on D at the moment of load.
//  Width rules
//  - D = 3-bit binary index.
//  - Pointer wrap is modulo 8.
//  - A and pending are bit-for-bit aligned: bit i <-> D=i.
// TESTING
//  T1 reset: rst_n=0 for 2 cycles with A=8'hFF, E=1 -> after release valid=0, pending=8'h00,
//     overflow=0, D=0.
//  T2 fixed priority: RR_MODE=0, ready=1, single pulse A=8'b1010_0100 -> D=2,5,7 with valid=1 on
//     3 consecutive cycles, then valid=0.
//  T3 backpressure: ready=0, pulse A=8'h01 -> D=0 valid held. Pulse A=8'h80 -> pending=8'h80.
//     Raise ready 1 cycle -> D=7 next cycle, pending=0.
//  T4 overflow: ready=0, D=0 shown, A=8'h08 then A=8'h08 again -> overflow=1, pending=8'h08.
//     ovf_clr=1 -> overflow=0. ovf_clr with a coincident overflow -> overflow stays 1.
//  T5 round-robin: RR_MODE=1, ready=1, pulse A=8'hFF -> D=0..7 in order. Then grant D=5 and pulse
//     A=8'h21 -> D=0 before D=5.
//  T6 enable/mid-op reset: E=0 with A=8'hFF -> no valid. E=1, queue 4 events, rst_n=0 mid-drain
//     -> valid=0 next cycle, pending=0.

Source files
------------

// File: rtl/event_encoder8x3.sv
// Queued 8-to-3 priority encoder: single-cycle event pulses are latched into a
// pending set and presented one at a time as a 3-bit index on a valid/ready port.
module event_encoder8x3 #(
    parameter bit RR_MODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] A,
    output logic [2:0] D,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int unsigned N_EVT = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [IDX_W-1:0]   d_q;
    logic [IDX_W-1:0]   d_n;
    logic               valid_q;
    logic               valid_n;
    logic [N_EVT-1:0]   pending_q;
    logic [N_EVT-1:0]   pending_n;
    logic               overflow_q;
    logic               overflow_n;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_n;

    logic [N_EVT-1:0]   cap_c;
    logic [N_EVT-1:0]   merged_c;
    logic [IDX_W-1:0]   sel_c;
    logic [N_EVT-1:0]   sel_onehot_c;
    logic               ovf_hit_c;

    // Captured requests merged with the pending set; the selector sees this directly.
    always_comb begin
        cap_c        = E ? A : '0;
        merged_c     = pending_q | cap_c;
        ovf_hit_c    = |(cap_c & pending_q);
    end

    // Pick the next index: lowest set bit, or first set bit after the last grant.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        sel_c = '0;
        if (RR_MODE) begin
            for (int unsigned k = 1; k <= N_EVT; k++) begin
                idx = ptr_q + IDX_W'(k);
                if (!found && merged_c[idx]) begin
                    sel_c = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_EVT; i++) begin
                if (!found && merged_c[i]) begin
                    sel_c = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
        sel_onehot_c = N_EVT'(1) << sel_c;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            d_q        <= '0;
            valid_q    <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            ptr_q      <= IDX_W'(N_EVT - 1);
        end else begin
            state_q    <= state_n;
            d_q        <= d_n;
            valid_q    <= valid_n;
            pending_q  <= pending_n;
            overflow_q <= overflow_n;
            ptr_q      <= ptr_n;
        end
    end

    // Next-state logic: load a new index from IDLE or on accept, otherwise hold D.
    always_comb begin
        state_n    = state_q;
        d_n        = d_q;
        valid_n    = valid_q;
        pending_n  = pending_q;
        ptr_n      = ptr_q;
        // Set wins over a coincident clear.
        overflow_n = (overflow_q && !ovf_clr) || ovf_hit_c;

        unique case (state_q)
            IDLE: begin
                if (merged_c != '0) begin
                    d_n       = sel_c;
                    valid_n   = 1'b1;
                    pending_n = merged_c & ~sel_onehot_c;
                    ptr_n     = sel_c;
                    state_n   = SHOW;
                end else begin
                    valid_n   = 1'b0;
                    pending_n = merged_c;
                end
            end
            SHOW: begin
                if (!ready) begin
                    pending_n = pending_q | cap_c;
                end else if (merged_c != '0) begin
                    d_n       = sel_c;
                    valid_n   = 1'b1;
                    pending_n = merged_c & ~sel_onehot_c;
                    ptr_n     = sel_c;
                end else begin
                    valid_n   = 1'b0;
                    pending_n = merged_c;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    assign D        = d_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_event_encoder8x3.sv
// Directed bench for event_encoder8x3: fixed-priority and round-robin instances
// share one stimulus stream; each scenario task checks its own expectations.
module tb_event_encoder8x3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       E;
    logic [7:0] A;
    logic       ready;
    logic       ovf_clr;

    logic [2:0] d0, d1;
    logic       valid0, valid1;
    logic [7:0] pending0, pending1;
    logic       overflow0, overflow1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    event_encoder8x3 #(.RR_MODE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .E(E), .A(A), .D(d0), .valid(valid0),
        .ready(ready), .pending(pending0), .overflow(overflow0), .ovf_clr(ovf_clr)
    );

    event_encoder8x3 #(.RR_MODE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .E(E), .A(A), .D(d1), .valid(valid1),
        .ready(ready), .pending(pending1), .overflow(overflow1), .ovf_clr(ovf_clr)
    );

    // Advance one rising edge and settle outputs before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; E = 1'b1; A = 8'h00; ready = 1'b0; ovf_clr = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; E = 1'b1; A = 8'hFF; ready = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1; A = 8'h00;
        checks++;
        if ({valid0, pending0, overflow0, d0} !== {1'b0, 8'h00, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_dut0: got v=%b p=%h o=%b d=%0d, want v=0 p=00 o=0 d=0",
                     valid0, pending0, overflow0, d0);
        end
        checks++;
        if ({valid1, pending1, overflow1, d1} !== {1'b0, 8'h00, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_dut1: got v=%b p=%h o=%b d=%0d, want v=0 p=00 o=0 d=0",
                     valid1, pending1, overflow1, d1);
        end
        tick();
        checks++;
        if (valid0 !== 1'b0 || pending0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_quiet: got v=%b p=%h, want v=0 p=00", valid0, pending0);
        end
    endtask

    task automatic test_fixed_priority();
        logic [2:0] exp_d [3];
        exp_d[0] = 3'd2; exp_d[1] = 3'd5; exp_d[2] = 3'd7;
        do_reset();
        ready = 1'b1;
        A = 8'b1010_0100;
        tick();
        A = 8'h00;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid0 !== 1'b1 || d0 !== exp_d[i]) begin
                errors++;
                $display("FAIL fixed_seq[%0d]: got v=%b d=%0d, want v=1 d=%0d",
                         i, valid0, d0, exp_d[i]);
            end
            tick();
        end
        checks++;
        if (valid0 !== 1'b0 || d0 !== 3'd7) begin
            errors++;
            $display("FAIL fixed_end: got v=%b d=%0d, want v=0 d=7", valid0, d0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0;
        A = 8'h01;
        tick();
        A = 8'h80;
        tick();
        A = 8'h00;
        checks++;
        if (valid0 !== 1'b1 || d0 !== 3'd0 || pending0 !== 8'h80) begin
            errors++;
            $display("FAIL bp_hold: got v=%b d=%0d p=%h, want v=1 d=0 p=80", valid0, d0, pending0);
        end
        tick();
        checks++;
        if (valid0 !== 1'b1 || d0 !== 3'd0) begin
            errors++;
            $display("FAIL bp_stable: got v=%b d=%0d, want v=1 d=0", valid0, d0);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (valid0 !== 1'b1 || d0 !== 3'd7 || pending0 !== 8'h00) begin
            errors++;
            $display("FAIL bp_release: got v=%b d=%0d p=%h, want v=1 d=7 p=00", valid0, d0, pending0);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (valid0 !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b, want v=0", valid0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        ready = 1'b0;
        A = 8'h01;
        tick();
        A = 8'h08;
        tick();
        checks++;
        if (overflow0 !== 1'b0 || pending0 !== 8'h08) begin
            errors++;
            $display("FAIL ovf_first: got o=%b p=%h, want o=0 p=08", overflow0, pending0);
        end
        tick();
        A = 8'h00;
        checks++;
        if (overflow0 !== 1'b1 || pending0 !== 8'h08 || d0 !== 3'd0) begin
            errors++;
            $display("FAIL ovf_set: got o=%b p=%h d=%0d, want o=1 p=08 d=0", overflow0, pending0, d0);
        end
        ovf_clr = 1'b1;
        tick();
        checks++;
        if (overflow0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got o=%b, want o=0", overflow0);
        end
        A = 8'h08;
        tick();
        A = 8'h00;
        checks++;
        if (overflow0 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got o=%b, want o=1", overflow0);
        end
        tick();
        ovf_clr = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++;
        if (valid0 !== 1'b1 || d0 !== 3'd3 || pending0 !== 8'h00 || overflow0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: got v=%b d=%0d p=%h o=%b, want v=1 d=3 p=00 o=0",
                     valid0, d0, pending0, overflow0);
        end
        // Same index as the one on D, with pending clear, queues rather than overflows.
        A = 8'h08;
        tick();
        A = 8'h00;
        checks++;
        if (overflow0 !== 1'b0 || pending0 !== 8'h08 || d0 !== 3'd3) begin
            errors++;
            $display("FAIL ovf_on_d: got o=%b p=%h d=%0d, want o=0 p=08 d=3", overflow0, pending0, d0);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ready = 1'b1;
        A = 8'hFF;
        tick();
        A = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (valid1 !== 1'b1 || d1 !== 3'(i)) begin
                errors++;
                $display("FAIL rr_sweep[%0d]: got v=%b d=%0d, want v=1 d=%0d", i, valid1, d1, i);
            end
            tick();
        end
        checks++;
        if (valid1 !== 1'b0) begin
            errors++;
            $display("FAIL rr_sweep_end: got v=%b, want v=0", valid1);
        end
        A = 8'h20;
        tick();
        A = 8'h21;
        tick();
        A = 8'h00;
        checks++;
        if (valid1 !== 1'b1 || d1 !== 3'd0) begin
            errors++;
            $display("FAIL rr_wrap_first: got v=%b d=%0d, want v=1 d=0", valid1, d1);
        end
        tick();
        checks++;
        if (valid1 !== 1'b1 || d1 !== 3'd5) begin
            errors++;
            $display("FAIL rr_wrap_second: got v=%b d=%0d, want v=1 d=5", valid1, d1);
        end
        // Pointer now 5: round-robin serves 6 before 3, fixed priority serves 3 first.
        A = 8'h48;
        tick();
        A = 8'h00;
        checks++;
        if (d1 !== 3'd6 || d0 !== 3'd3) begin
            errors++;
            $display("FAIL rr_vs_fixed_a: got rr=%0d fixed=%0d, want rr=6 fixed=3", d1, d0);
        end
        tick();
        checks++;
        if (d1 !== 3'd3 || d0 !== 3'd6) begin
            errors++;
            $display("FAIL rr_vs_fixed_b: got rr=%0d fixed=%0d, want rr=3 fixed=6", d1, d0);
        end
        tick();
        ready = 1'b0;
    endtask

    task automatic test_enable_midop_reset();
        do_reset();
        E = 1'b0;
        ready = 1'b1;
        A = 8'hFF;
        tick();
        tick();
        A = 8'h00;
        checks++;
        if (valid0 !== 1'b0 || pending0 !== 8'h00 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL en_ignore: got v0=%b p0=%h v1=%b, want v0=0 p0=00 v1=0",
                     valid0, pending0, valid1);
        end
        E = 1'b1;
        A = 8'h0F;
        tick();
        A = 8'h00;
        tick();
        checks++;
        if (valid0 !== 1'b1 || d0 !== 3'd1 || pending0 !== 8'h0C) begin
            errors++;
            $display("FAIL mid_drain: got v=%b d=%0d p=%h, want v=1 d=1 p=0c", valid0, d0, pending0);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (valid0 !== 1'b0 || pending0 !== 8'h00 || d0 !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b p=%h d=%0d, want v=0 p=00 d=0", valid0, pending0, d0);
        end
        tick();
        tick();
        checks++;
        if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: got v0=%b v1=%b, want 0 0", valid0, valid1);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_backpressure();
        test_overflow();
        test_round_robin();
        test_enable_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
